mem_arbiter: RTL and testbench
==============================

Name:
mem_arbiter

Overview:
- Shares one synchronous single-port memory among three requesters: instruction fetch (I), data load/store (D) and external debug/loader (X).
- Sits between the mcpu pipeline ports and the memory macro.
- Pipelined: one access per cycle. A read tag shift register routes each returning word to the requester that issued it.

Parameters:
AW, 32, address width of all address ports
DW, 32, data width of all data ports
MEM_LAT, 1, memory read latency in cycles (legal 1..4)

Ports:
CLK  input  1  CPU clock; all state changes on posedge
RESET_N  input  1  asynchronous reset, active-low
I_REQ  input  1  instruction fetch read request
I_ADDR  input  AW  fetch address
I_GNT  output  1  fetch accepted this cycle
I_RVALID  output  1  RDATA holds fetch result
D_REQ  input  1  data access request
D_WE  input  1  1 = write, 0 = read
D_ADDR  input  AW  data address
D_WDATA  input  DW  store data
D_GNT  output  1  data access accepted this cycle
D_RVALID  output  1  RDATA holds load result
X_REQ  input  1  debug access request
X_WE  input  1  1 = write, 0 = read
X_ADDR  input  AW  debug address
X_WDATA  input  DW  debug write data
X_GNT  output  1  debug access accepted this cycle
X_RVALID  output  1  RDATA holds debug read result
RDATA  output  DW  read data, broadcast to all requesters
MEM_EN  output  1  memory access strobe
MEM_WE  output  1  memory write enable
MEM_ADDR  output  AW  memory address
MEM_WDATA  output  DW  memory write data
MEM_RDATA  input  DW  memory read data, valid MEM_LAT cycles after MEM_EN

Behaviour:
- Handshake:
  - GNT is combinational from REQ and the arbiter state.
  - An access is accepted in a cycle where REQ and GNT are both 1.
  - A requester holds REQ, ADDR, WE and WDATA stable until it sees GNT.
  - REQ must not depend combinationally on GNT.
- Priority:
  - X has strict priority over D and I.
  - D and I use round-robin via a 1-bit last-winner flag. The flag updates only on a D or I grant. Reset value = I, so D wins the first tie.
  - A lone requester is granted every cycle.
- At most one GNT is high per cycle. MEM_EN = OR of the GNTs.
- MEM_WE/ADDR/WDATA:
  - Muxed from the granted requester; I is always a read.
  - When MEM_EN = 0, all three are 0.
- Read tags:
  - A MEM_LAT-deep shift register of {valid, id[1:0]} advances every cycle.
  - A granted read enters the register with valid=1; a write enters with valid=0.
  - The matching *_RVALID pulses for exactly one cycle, MEM_LAT cycles after the accept cycle.
- RDATA = MEM_RDATA, passthrough with no extra register.
- Writes produce no RVALID. Back-to-back read and write from different requesters are legal with no bubble.
- While RESET_N = 0:
  - All GNT, RVALID and MEM_* outputs are 0.
  - The tag register and last-winner flag are cleared.
  - In-flight reads are dropped and never produce RVALID after release.
- Release of RESET_N is synchronised by the caller. Grants resume on the first posedge after release.

Optional Feature:
MEM_ARB_PERF_EN:
- Defined: adds output PERF_CONFLICT (16 bits). It counts cycles with two or more REQ high, saturates at 16'hFFFF and is cleared by reset.
- Undefined: the port and counter are absent and behaviour is otherwise identical.

Test Plan:
1. MEM_LAT=1, only I_REQ=1 with I_ADDR 0,4,8 on consecutive cycles -> I_GNT=1 every cycle; I_RVALID one cycle after each accept; RDATA = mem[0], mem[4], mem[8].
2. D_REQ and I_REQ held at 1 (reads) from reset release -> grants D,I,D,I,...; D wins the first tie; MEM_ADDR alternates accordingly.
3. X_REQ=1 for 4 cycles while D and I request -> X_GNT=1 for 4 cycles with D_GNT=I_GNT=0; round-robin then resumes with the side not last granted.
4. MEM_LAT=3: D read @0x10 at cycle 0, I read @0x20 at cycle 1, D write at cycle 2 -> D_RVALID at cycle 3, I_RVALID at cycle 4, no RVALID at cycle 5.
5. Two reads in flight with MEM_LAT=3, RESET_N pulsed low for 1 cycle -> no RVALID ever fires for them; all outputs 0 during reset; first tie after release goes to D.
6. MEM_ARB_PERF_EN defined: 5 cycles with D_REQ and I_REQ both high -> PERF_CONFLICT=5; force 70000 conflicts -> PERF_CONFLICT=16'hFFFF.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one synchronous single-port memory between fetch (I), data (D) and debug (X)
// requesters; a read-tag pipe routes returning words. `define MEM_ARB_PERF_EN adds PERF_CONFLICT.
module mem_arbiter #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int MEM_LAT = 1
) (
  input  logic          CLK,
  input  logic          RESET_N,
  input  logic          I_REQ,
  input  logic [AW-1:0] I_ADDR,
  output logic          I_GNT,
  output logic          I_RVALID,
  input  logic          D_REQ,
  input  logic          D_WE,
  input  logic [AW-1:0] D_ADDR,
  input  logic [DW-1:0] D_WDATA,
  output logic          D_GNT,
  output logic          D_RVALID,
  input  logic          X_REQ,
  input  logic          X_WE,
  input  logic [AW-1:0] X_ADDR,
  input  logic [DW-1:0] X_WDATA,
  output logic          X_GNT,
  output logic          X_RVALID,
  output logic [DW-1:0] RDATA,
`ifdef MEM_ARB_PERF_EN
  output logic [15:0]   PERF_CONFLICT,
`endif
  output logic          MEM_EN,
  output logic          MEM_WE,
  output logic [AW-1:0] MEM_ADDR,
  output logic [DW-1:0] MEM_WDATA,
  input  logic [DW-1:0] MEM_RDATA
);

  typedef enum logic [1:0] {
    ID_I = 2'd0,
    ID_D = 2'd1,
    ID_X = 2'd2
  } req_id_e;

  typedef struct packed {
    logic    vld;
    req_id_e id;
  } tag_t;

  logic    r_last_d;          // 1: D won the last D/I arbitration, 0: I did (reset)
  tag_t    r_tag [MEM_LAT];
  logic    w_i_win;
  logic    w_d_win;
  logic    w_x_win;
  logic    w_any;
  req_id_e w_id;
  tag_t    w_tag_in;
  tag_t    w_tag_out;

  // Grants are gated by RESET_N so nothing reaches the memory while in reset.
  always_comb begin
    w_x_win = RESET_N & X_REQ;
    w_d_win = RESET_N & ~X_REQ & D_REQ & (~I_REQ | ~r_last_d);
    w_i_win = RESET_N & ~X_REQ & I_REQ & (~D_REQ |  r_last_d);
    w_any   = w_x_win | w_d_win | w_i_win;
  end

  always_comb begin
    MEM_WE    = 1'b0;
    MEM_ADDR  = '0;
    MEM_WDATA = '0;
    w_id      = ID_I;
    if (w_x_win) begin
      MEM_WE    = X_WE;
      MEM_ADDR  = X_ADDR;
      MEM_WDATA = X_WDATA;
      w_id      = ID_X;
    end else if (w_d_win) begin
      MEM_WE    = D_WE;
      MEM_ADDR  = D_ADDR;
      MEM_WDATA = D_WDATA;
      w_id      = ID_D;
    end else if (w_i_win) begin
      MEM_ADDR  = I_ADDR;
      w_id      = ID_I;
    end
  end

  assign MEM_EN = w_any;
  assign I_GNT  = w_i_win;
  assign D_GNT  = w_d_win;
  assign X_GNT  = w_x_win;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_last_d <= 1'b0;
    end else if (w_d_win) begin
      r_last_d <= 1'b1;
    end else if (w_i_win) begin
      r_last_d <= 1'b0;
    end
  end

  // Writes still occupy a slot in the tag pipe, but with vld=0 they never raise RVALID.
  assign w_tag_in = '{vld: w_any & ~MEM_WE, id: w_id};

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      for (int k = 0; k < MEM_LAT; k++) begin
        r_tag[k] <= '0;
      end
    end else begin
      r_tag[0] <= w_tag_in;
      for (int k = 1; k < MEM_LAT; k++) begin
        r_tag[k] <= r_tag[k-1];
      end
    end
  end

  assign w_tag_out = r_tag[MEM_LAT-1];
  assign I_RVALID  = w_tag_out.vld & (w_tag_out.id == ID_I);
  assign D_RVALID  = w_tag_out.vld & (w_tag_out.id == ID_D);
  assign X_RVALID  = w_tag_out.vld & (w_tag_out.id == ID_X);
  assign RDATA     = MEM_RDATA;

`ifdef MEM_ARB_PERF_EN
  logic [15:0] r_perf;
  logic        w_conflict;

  assign w_conflict = (I_REQ & D_REQ) | (I_REQ & X_REQ) | (D_REQ & X_REQ);

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_perf <= '0;
    end else if (w_conflict && (r_perf != 16'hFFFF)) begin
      r_perf <= r_perf + 16'd1;
    end
  end

  assign PERF_CONFLICT = r_perf;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: drives a MEM_LAT=1 and a MEM_LAT=3 arbiter with identical stimulus and checks both
// every cycle against a queue-based reference model; directed literal checks pin the model.
module tb_mem_arbiter;
  localparam int LAT0 = 1;
  localparam int LAT1 = 3;

  logic        CLK;
  logic        RESET_N;
  logic        I_REQ, D_REQ, D_WE, X_REQ, X_WE;
  logic [31:0] I_ADDR, D_ADDR, D_WDATA, X_ADDR, X_WDATA;

  wire  [1:0]       i_gnt, d_gnt, x_gnt, i_rv, d_rv, x_rv, mem_en, mem_we;
  wire  [1:0][31:0] rdata, mem_addr, mem_wdata;
  logic [1:0][31:0] mem_rdata;
`ifdef MEM_ARB_PERF_EN
  wire  [1:0][15:0] perf;
`endif

  int total = 0;
  int bad   = 0;

  mem_arbiter #(.AW(32), .DW(32), .MEM_LAT(LAT0)) u_dut0 (
    .CLK(CLK), .RESET_N(RESET_N),
    .I_REQ(I_REQ), .I_ADDR(I_ADDR), .I_GNT(i_gnt[0]), .I_RVALID(i_rv[0]),
    .D_REQ(D_REQ), .D_WE(D_WE), .D_ADDR(D_ADDR), .D_WDATA(D_WDATA), .D_GNT(d_gnt[0]), .D_RVALID(d_rv[0]),
    .X_REQ(X_REQ), .X_WE(X_WE), .X_ADDR(X_ADDR), .X_WDATA(X_WDATA), .X_GNT(x_gnt[0]), .X_RVALID(x_rv[0]),
    .RDATA(rdata[0]),
`ifdef MEM_ARB_PERF_EN
    .PERF_CONFLICT(perf[0]),
`endif
    .MEM_EN(mem_en[0]), .MEM_WE(mem_we[0]), .MEM_ADDR(mem_addr[0]), .MEM_WDATA(mem_wdata[0]),
    .MEM_RDATA(mem_rdata[0])
  );

  mem_arbiter #(.AW(32), .DW(32), .MEM_LAT(LAT1)) u_dut1 (
    .CLK(CLK), .RESET_N(RESET_N),
    .I_REQ(I_REQ), .I_ADDR(I_ADDR), .I_GNT(i_gnt[1]), .I_RVALID(i_rv[1]),
    .D_REQ(D_REQ), .D_WE(D_WE), .D_ADDR(D_ADDR), .D_WDATA(D_WDATA), .D_GNT(d_gnt[1]), .D_RVALID(d_rv[1]),
    .X_REQ(X_REQ), .X_WE(X_WE), .X_ADDR(X_ADDR), .X_WDATA(X_WDATA), .X_GNT(x_gnt[1]), .X_RVALID(x_rv[1]),
    .RDATA(rdata[1]),
`ifdef MEM_ARB_PERF_EN
    .PERF_CONFLICT(perf[1]),
`endif
    .MEM_EN(mem_en[1]), .MEM_WE(mem_we[1]), .MEM_ADDR(mem_addr[1]), .MEM_WDATA(mem_wdata[1]),
    .MEM_RDATA(mem_rdata[1])
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  function automatic int lat_of(input int k);
    return (k == 0) ? LAT0 : LAT1;
  endfunction

  task automatic chk(input string nm, input int k, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s dut%0d: got %h want %h (t=%0t)", nm, k, act, exp, $time);
    end
  endtask

  // Behavioural memory macros, one per DUT; MEM_* sampled mid-cycle, applied on posedge.
  logic [31:0] mem   [2][256];
  logic [31:0] mpipe [2][4];
  initial begin
    logic       s_en [2];
    logic       s_we [2];
    logic [7:0] s_ix [2];
    logic [31:0] s_wd [2];
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 256; i++) mem[k][i] = 32'hC0DE_0000 | i;
      for (int j = 0; j < 4; j++) mpipe[k][j] = 32'hDEAD_BEEF;
    end
    mem_rdata = {32'hDEAD_BEEF, 32'hDEAD_BEEF};
    forever begin
      @(negedge CLK);
      for (int k = 0; k < 2; k++) begin
        s_en[k] = mem_en[k]; s_we[k] = mem_we[k];
        s_ix[k] = mem_addr[k][9:2]; s_wd[k] = mem_wdata[k];
      end
      @(posedge CLK);
      for (int k = 0; k < 2; k++) begin
        for (int j = 3; j > 0; j--) mpipe[k][j] = mpipe[k][j-1];
        mpipe[k][0] = (s_en[k] && !s_we[k]) ? mem[k][s_ix[k]] : 32'hDEAD_BEEF;
        if (s_en[k] && s_we[k]) mem[k][s_ix[k]] = s_wd[k];
      end
      mem_rdata[0] = mpipe[0][LAT0-1];
      mem_rdata[1] = mpipe[1][LAT1-1];
    end
  end

  // Reference model: arbitration from the priority rules, reads as (due cycle, requester, data).
  typedef struct {
    int          k;
    int          due;
    int          id;
    logic [31:0] data;
  } pend_t;

  initial begin
    pend_t       pq[$];
    logic [31:0] mmodel [256];
    logic        m_last_d;
    int          cyc;
    int          win;
    logic        e_we;
    logic [31:0] e_addr, e_wd;
    logic [2:0]  e_rv [2];
    logic [31:0] e_dat [2];
    int          nreq;
    logic [15:0] m_perf;
    for (int i = 0; i < 256; i++) mmodel[i] = 32'hC0DE_0000 | i;
    m_last_d = 1'b0;
    m_perf   = '0;
    cyc      = 0;
    forever begin
      @(negedge CLK);
      nreq = int'(I_REQ) + int'(D_REQ) + int'(X_REQ);
      if (!RESET_N) begin
        for (int k = 0; k < 2; k++) begin
          chk("rst_gnt", k, {x_gnt[k], d_gnt[k], i_gnt[k]}, 0);
          chk("rst_rvalid", k, {x_rv[k], d_rv[k], i_rv[k]}, 0);
          chk("rst_mem", k, {mem_en[k], mem_we[k], mem_addr[k]}, 0);
          chk("rst_wdata", k, mem_wdata[k], 0);
`ifdef MEM_ARB_PERF_EN
          chk("rst_perf", k, perf[k], 0);
`endif
        end
        pq.delete();
        m_last_d = 1'b0;
        m_perf   = '0;
      end else begin
        if (X_REQ)               win = 2;
        else if (D_REQ && I_REQ) win = m_last_d ? 0 : 1;
        else if (D_REQ)          win = 1;
        else if (I_REQ)          win = 0;
        else                     win = 3;
        e_we   = (win == 2) ? X_WE    : (win == 1) ? D_WE    : 1'b0;
        e_addr = (win == 2) ? X_ADDR  : (win == 1) ? D_ADDR  : (win == 0) ? I_ADDR : 32'd0;
        e_wd   = (win == 2) ? X_WDATA : (win == 1) ? D_WDATA : 32'd0;
        for (int k = 0; k < 2; k++) begin
          e_rv[k]  = 3'b000;
          e_dat[k] = '0;
        end
        foreach (pq[j]) begin
          if (pq[j].due == cyc) begin
            e_rv[pq[j].k][pq[j].id] = 1'b1;
            e_dat[pq[j].k]          = pq[j].data;
          end
        end
        pq = pq.find(item) with (item.due > cyc);
        for (int k = 0; k < 2; k++) begin
          chk("gnt", k, {x_gnt[k], d_gnt[k], i_gnt[k]}, (win == 3) ? 3'b000 : (3'b001 << win));
          chk("mem_en", k, mem_en[k], win != 3);
          chk("mem_we", k, mem_we[k], e_we);
          chk("mem_addr", k, mem_addr[k], e_addr);
          if (win == 3 || e_we) chk("mem_wdata", k, mem_wdata[k], e_wd);
          chk("rvalid", k, {x_rv[k], d_rv[k], i_rv[k]}, e_rv[k]);
          if (e_rv[k] != 3'b000) chk("rdata", k, rdata[k], e_dat[k]);
`ifdef MEM_ARB_PERF_EN
          chk("perf", k, perf[k], m_perf);
`endif
        end
        if (nreq >= 2 && m_perf != 16'hFFFF) m_perf = m_perf + 16'd1;
        if (win == 0 || win == 1) m_last_d = (win == 1);
        if (win != 3) begin
          if (e_we) mmodel[e_addr[9:2]] = e_wd;
          else for (int k = 0; k < 2; k++)
            pq.push_back('{k: k, due: cyc + lat_of(k), id: win, data: mmodel[e_addr[9:2]]});
        end
      end
      cyc++;
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic rst_pulse();
    RESET_N = 1'b0;
    tick();
    RESET_N = 1'b1;
  endtask

  function automatic logic [31:0] raddr();
    return 32'($urandom_range(0, 63)) << 2;
  endfunction

  initial begin
    logic gi, gd, gx;
    RESET_N = 1'b0;
    I_REQ = 0; I_ADDR = 0; D_REQ = 0; D_WE = 0; D_ADDR = 0; D_WDATA = 0;
    X_REQ = 0; X_WE = 0; X_ADDR = 0; X_WDATA = 0;
    repeat (3) tick();
    RESET_N = 1'b1;

    // Lone fetch stream 0,4,8
    I_REQ = 1; I_ADDR = 32'h0;
    @(negedge CLK); chk("t1_gnt", 0, i_gnt[0], 1); chk("t1_addr", 0, mem_addr[0], 0);
    tick(); I_ADDR = 32'h4;
    @(negedge CLK); chk("t1_gnt", 0, i_gnt[0], 1); chk("t1_rv", 0, i_rv[0], 1);
    chk("t1_rd0", 0, rdata[0], 32'hC0DE_0000);
    tick(); I_ADDR = 32'h8;
    @(negedge CLK); chk("t1_rd1", 0, rdata[0], 32'hC0DE_0001);
    tick(); I_REQ = 0;
    @(negedge CLK); chk("t1_rv", 0, i_rv[0], 1); chk("t1_rd2", 0, rdata[0], 32'hC0DE_0002);
    chk("t1_rv", 1, i_rv[1], 1); chk("t1_rd0", 1, rdata[1], 32'hC0DE_0000);
    tick();

    // D/I round-robin from release, then X preemption
    D_REQ = 1; D_WE = 0; D_ADDR = 32'h40; I_REQ = 1; I_ADDR = 32'h80;
    rst_pulse();
    @(negedge CLK); chk("t2_first_d", 0, {d_gnt[0], i_gnt[0]}, 2'b10); chk("t2_addr", 0, mem_addr[0], 32'h40);
    tick();
    @(negedge CLK); chk("t2_then_i", 0, {d_gnt[0], i_gnt[0]}, 2'b01); chk("t2_addr", 0, mem_addr[0], 32'h80);
    tick();
    @(negedge CLK); chk("t2_then_d", 0, {d_gnt[0], i_gnt[0]}, 2'b10);
    tick();
    X_REQ = 1; X_WE = 0; X_ADDR = 32'hC0;
    for (int n = 0; n < 4; n++) begin
      @(negedge CLK); chk("t3_x_only", 0, {x_gnt[0], d_gnt[0], i_gnt[0]}, 3'b100);
      tick();
    end
    X_REQ = 0;
    @(negedge CLK); chk("t3_resume_i", 0, {d_gnt[0], i_gnt[0]}, 2'b01);
    tick();
    @(negedge CLK); chk("t3_then_d", 0, {d_gnt[0], i_gnt[0]}, 2'b10);
    tick();
    D_REQ = 0; I_REQ = 0;

    // MEM_LAT=3 read / read / write
    rst_pulse();
    D_REQ = 1; D_WE = 0; D_ADDR = 32'h10;
    @(negedge CLK); chk("t4_gnt_d", 1, d_gnt[1], 1);
    tick(); D_REQ = 0; I_REQ = 1; I_ADDR = 32'h20;
    @(negedge CLK); chk("t4_gnt_i", 1, i_gnt[1], 1);
    tick(); I_REQ = 0; D_REQ = 1; D_WE = 1; D_ADDR = 32'h30; D_WDATA = 32'h1234_5678;
    @(negedge CLK); chk("t4_we", 1, mem_we[1], 1);
    tick(); D_REQ = 0; D_WE = 0;
    @(negedge CLK); chk("t4_d_rv", 1, {x_rv[1], d_rv[1], i_rv[1]}, 3'b010); chk("t4_d_rd", 1, rdata[1], 32'hC0DE_0004);
    tick();
    @(negedge CLK); chk("t4_i_rv", 1, {x_rv[1], d_rv[1], i_rv[1]}, 3'b001); chk("t4_i_rd", 1, rdata[1], 32'hC0DE_0008);
    tick();
    @(negedge CLK); chk("t4_wr_no_rv", 1, {x_rv[1], d_rv[1], i_rv[1]}, 3'b000);
    tick();

    // Reset with two reads in flight
    D_REQ = 1; D_ADDR = 32'h14;
    tick(); D_REQ = 0; I_REQ = 1; I_ADDR = 32'h24;
    tick(); RESET_N = 0; D_REQ = 1; D_ADDR = 32'h44; I_ADDR = 32'h84;
    @(negedge CLK); chk("t5_rst_out", 1, {x_gnt[1], d_gnt[1], i_gnt[1], mem_en[1], x_rv[1], d_rv[1], i_rv[1]}, 0);
    tick(); RESET_N = 1;
    @(negedge CLK); chk("t5_tie_d", 1, {d_gnt[1], i_gnt[1]}, 2'b10); chk("t5_no_rv", 1, {x_rv[1], d_rv[1], i_rv[1]}, 0);
    tick();
    @(negedge CLK); chk("t5_then_i", 1, {d_gnt[1], i_gnt[1]}, 2'b01); chk("t5_no_rv", 1, {x_rv[1], d_rv[1], i_rv[1]}, 0);
    tick(); D_REQ = 0; I_REQ = 0;

    // Randomised traffic with occasional reset pulses
    for (int n = 0; n < 3000; n++) begin
      @(negedge CLK);
      gi = i_gnt[0]; gd = d_gnt[0]; gx = x_gnt[0];
      tick();
      if (!I_REQ || gi) begin
        I_REQ = ($urandom_range(0, 3) != 0); I_ADDR = raddr();
      end
      if (!D_REQ || gd) begin
        D_REQ = ($urandom_range(0, 3) != 0); D_WE = 1'($urandom_range(0, 1));
        D_ADDR = raddr(); D_WDATA = $urandom;
      end
      if (!X_REQ || gx) begin
        X_REQ = ($urandom_range(0, 7) == 0); X_WE = 1'($urandom_range(0, 1));
        X_ADDR = raddr(); X_WDATA = $urandom;
      end
      if (!RESET_N) RESET_N = 1;
      else if ($urandom_range(0, 299) == 0) RESET_N = 0;
    end
    RESET_N = 1; I_REQ = 0; D_REQ = 0; X_REQ = 0; D_WE = 0; X_WE = 0;
    tick();

`ifdef MEM_ARB_PERF_EN
    rst_pulse();
    D_REQ = 1; I_REQ = 1;
    repeat (5) tick();
    D_REQ = 0; I_REQ = 0;
    @(negedge CLK); chk("t6_perf5", 0, perf[0], 16'd5); chk("t6_perf5", 1, perf[1], 16'd5);
    tick();
    D_REQ = 1; I_REQ = 1;
    repeat (70000) tick();
    D_REQ = 0; I_REQ = 0;
    @(negedge CLK); chk("t6_sat", 0, perf[0], 16'hFFFF); chk("t6_sat", 1, perf[1], 16'hFFFF);
    tick();
`endif

    repeat (5) tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
